// File: rtl/generic_fifo_dc_pkg.sv
// Shared types for the generic_fifo_dc FIFO slice.
package generic_fifo_dc_pkg;
  typedef logic [1:0] level_t;
  localparam level_t LEVEL_TOP = 2'b11;
endpackage

// File: rtl/generic_fifo_dc_if.sv
// Producer/consumer bus of generic_fifo_dc: push, pop, clear and status flags.
interface generic_fifo_dc_if
  import generic_fifo_dc_pkg::*;
#(
  parameter int dw = 8
);
  logic          clr;
  logic [dw-1:0] din;
  logic          we;
  logic          re;
  logic [dw-1:0] dout;
  logic          full;
  logic          empty;
  logic          full_n;
  logic          empty_n;
  level_t        level;

  modport master (
    output clr, din, we, re,
    input  dout, full, empty, full_n, empty_n, level
  );

  modport slave (
    input  clr, din, we, re,
    output dout, full, empty, full_n, empty_n, level
  );
endinterface

// File: rtl/generic_fifo_dc_fifo_ram.sv
// 2^aw x dw storage: synchronous write, registered read that holds when not enabled.
module fifo_ram
  import generic_fifo_dc_pkg::*;
#(
  parameter int dw = 8,
  parameter int aw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [aw-1:0] waddr_i,
  input  logic [dw-1:0] wdata_i,
  input  logic          re_i,
  input  logic [aw-1:0] raddr_i,
  output logic [dw-1:0] rdata_o
);
  logic [dw-1:0] mem [2**aw];
  logic [dw-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; the array keeps whatever it held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/generic_fifo_dc.sv
// Single-clock FIFO with registered read port, exact and threshold flags, coarse fill level.
module generic_fifo_dc
  import generic_fifo_dc_pkg::*;
#(
  parameter int dw = 8,
  parameter int aw = 8,
  parameter int n  = 32
) (
  input  logic           clk,
  input  logic           rst,
  generic_fifo_dc_if.slave bus
);
  localparam logic [aw:0] DEPTH     = {1'b1, {aw{1'b0}}};
  localparam logic [aw:0] N_TH      = (aw+1)'(n);
  localparam logic [aw:0] FULL_N_TH = DEPTH - N_TH;

  logic [aw-1:0] wp_q, wp_d;
  logic [aw-1:0] rp_q, rp_d;
  logic [aw:0]   cnt_q, cnt_d;
  logic          full, empty;
  logic          wr_acc, rd_acc;
  logic [dw-1:0] dout;

  // Clear wins over traffic, so it also blocks the RAM write and the dout load.
  assign wr_acc = bus.we & ~full  & ~bus.clr;
  assign rd_acc = bus.re & ~empty & ~bus.clr;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (bus.clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (wr_acc) wp_d = wp_q + 1'b1;
      if (rd_acc) rp_d = rp_q + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  fifo_ram #(.dw(dw), .aw(aw)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wp_q),
    .wdata_i (bus.din),
    .re_i    (rd_acc),
    .raddr_i (rp_q),
    .rdata_o (dout)
  );

  // Occupancy alone separates full from empty; pointers are equal in both cases.
  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == DEPTH);
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.empty_n = (cnt_q < N_TH);
  assign bus.full_n  = (cnt_q > FULL_N_TH);
  assign bus.level   = cnt_q[aw] ? LEVEL_TOP : cnt_q[aw-1:aw-2];
  assign bus.dout    = dout;
endmodule

// File: tb/tb_generic_fifo_dc.sv
// Self-checking bench for generic_fifo_dc: hand table, corner sequences and random traffic vs a queue model.
module tb_generic_fifo_dc;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int N  = 9;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  generic_fifo_dc_if #(.dw(DW)) bus ();

  generic_fifo_dc #(.dw(DW), .aw(AW), .n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] dout_m = '0;
  int acc_w = 0;
  int acc_r = 0;

  typedef struct {
    bit            we;
    bit            re;
    bit            clr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
    bit            exp_empty;
    logic [1:0]    exp_level;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a queue of accepted words plus the last popped word.
  task automatic model_apply(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    bit rd, wr;
    if (c) begin
      q.delete();
    end else begin
      rd = r && (q.size() > 0);
      wr = w && (q.size() < DEPTH);
      if (rd) begin
        dout_m = q.pop_front();
        acc_r++;
      end
      if (wr) begin
        q.push_back(d);
        acc_w++;
      end
    end
  endtask

  task automatic check_model(input string name);
    int sz;
    int lvl;
    sz  = q.size();
    lvl = (sz >= 3 * DEPTH / 4) ? 3 : sz / (DEPTH / 4);
    chk({name, ".empty"},   32'(bus.empty),   32'(sz == 0));
    chk({name, ".full"},    32'(bus.full),    32'(sz == DEPTH));
    chk({name, ".empty_n"}, 32'(bus.empty_n), 32'(sz < N));
    chk({name, ".full_n"},  32'(bus.full_n),  32'(DEPTH - sz < N));
    chk({name, ".level"},   32'(bus.level),   32'(lvl));
    chk({name, ".dout"},    32'(bus.dout),    32'(dout_m));
  endtask

  task automatic step(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    bus.we = w; bus.re = r; bus.clr = c; bus.din = d;
    model_apply(w, r, c, d);
    @(posedge clk); #1;
    bus.we = 1'b0; bus.re = 1'b0; bus.clr = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    q.delete();
    dout_m = '0;
    chk("rst.empty",   32'(bus.empty),   32'd1);
    chk("rst.empty_n", 32'(bus.empty_n), 32'd1);
    chk("rst.full",    32'(bus.full),    32'd0);
    chk("rst.full_n",  32'(bus.full_n),  32'd0);
    chk("rst.level",   32'(bus.level),   32'd0);
    chk("rst.dout",    32'(bus.dout),    32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 2'b00};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b1, 2'b00};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b1, 2'b00};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h3C, 8'hA5, 1'b0, 2'b00};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h11, 8'hA5, 1'b0, 2'b00};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 8'h22, 8'h3C, 1'b0, 2'b00};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 8'h99, 8'h3C, 1'b1, 2'b00};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h44, 8'h3C, 1'b0, 2'b00};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h44, 1'b1, 2'b00};

    bus.we = 1'b0; bus.re = 1'b0; bus.clr = 1'b0; bus.din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check_model("init");

    // Reset pulse mid-run, then a read attempt on the emptied FIFO.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    do_reset();
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rst.read_after", 32'(bus.dout), 32'd0);
    check_model("rst.after");

    // Hand-derived vectors: single write/read, empty read, simultaneous ops, clear.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].we, tbl[i].re, tbl[i].clr, tbl[i].din);
      chk($sformatf("tbl%0d.dout", i),  32'(bus.dout),  32'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d.empty", i), 32'(bus.empty), 32'(tbl[i].exp_empty));
      chk($sformatf("tbl%0d.level", i), 32'(bus.level), 32'(tbl[i].exp_level));
      check_model($sformatf("tbl%0d", i));
    end

    // Fill to full, checking thresholds at their exact counts.
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b1, 1'b0, 1'b0, 8'(k) ^ 8'h5A);
      check_model("fill");
      if (k == 8)   chk("fill.empty_n@8",   32'(bus.empty_n), 32'd1);
      if (k == 9)   chk("fill.empty_n@9",   32'(bus.empty_n), 32'd0);
      if (k == 63)  chk("fill.level@63",    32'(bus.level),   32'd0);
      if (k == 64)  chk("fill.level@64",    32'(bus.level),   32'd1);
      if (k == 128) chk("fill.level@128",   32'(bus.level),   32'd2);
      if (k == 192) chk("fill.level@192",   32'(bus.level),   32'd3);
      if (k == 247) chk("fill.full_n@247",  32'(bus.full_n),  32'd0);
      if (k == 248) chk("fill.full_n@248",  32'(bus.full_n),  32'd1);
      if (k == 255) chk("fill.full@255",    32'(bus.full),    32'd0);
      if (k == 256) chk("fill.full@256",    32'(bus.full),    32'd1);
    end
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    chk("drop257.full", 32'(bus.full), 32'd1);
    check_model("drop257");

    // Read and write together at full: write dropped, one word popped.
    step(1'b1, 1'b1, 1'b0, 8'hDD);
    chk("rw_full.dout", 32'(bus.dout), 32'(8'h01 ^ 8'h5A));
    chk("rw_full.full", 32'(bus.full), 32'd0);
    check_model("rw_full");
    while (q.size() > 0) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check_model("drain_full");
    end

    // Read and write together at cnt=5: occupancy holds, order kept.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    step(1'b1, 1'b1, 1'b0, 8'hC5);
    chk("rw5.dout", 32'(bus.dout), 32'hC0);
    check_model("rw5");
    while (q.size() > 0) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check_model("drain5");
    end
    chk("drain5.last", 32'(bus.dout), 32'hC5);

    // Read and write together at empty: write taken, dout unchanged.
    step(1'b1, 1'b1, 1'b0, 8'h77);
    chk("rw_empty.dout",  32'(bus.dout),  32'hC5);
    chk("rw_empty.empty", 32'(bus.empty), 32'd0);
    check_model("rw_empty");
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rw_empty.pop", 32'(bus.dout), 32'h77);

    // Clear with a concurrent write, then fresh traffic.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
    step(1'b1, 1'b0, 1'b1, 8'hAB);
    chk("clr.empty", 32'(bus.empty), 32'd1);
    chk("clr.dout",  32'(bus.dout),  32'h77);
    check_model("clr");
    step(1'b1, 1'b0, 1'b0, 8'h6D);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("clr.new_word", 32'(bus.dout), 32'h6D);
    check_model("clr.after");

    // Random bursts: long enough for several pointer wraps.
    acc_r = 0;
    while (acc_r < 1100) begin
      int nw, nr, ni;
      nw = int'($urandom_range(4, 1));
      nr = int'($urandom_range(4, 1));
      ni = int'($urandom_range(4, 0));
      for (int i = 0; i < nw; i++) begin
        step(1'b1, 1'b0, 1'b0, 8'($urandom));
        check_model("rnd.w");
      end
      for (int i = 0; i < nr; i++) begin
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("rnd.x", 32'($isunknown(bus.dout)), 32'd0);
        check_model("rnd.r");
      end
      for (int i = 0; i < ni; i++) begin
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_model("rnd.idle");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
